// File: rtl/caesar_pkg.sv
// Shared types and constants for the Caesar character front-end.
// Optional key rolling is enabled by defining CAESAR_KEY_ROLL_EN.
package caesar_pkg;

    localparam int unsigned LETTERS = 26;

    localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
    localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
    localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;

    typedef enum logic {StNoKey, StRun} state_e;

    typedef struct packed {
        logic [4:0] index;
        logic       cap;
        logic       bypass;
        logic [7:0] raw;
        logic [4:0] key;
        logic       dir;
    } entry_t;

    // Build a buffer entry from a raw byte and the key in effect at acceptance.
    function automatic entry_t classify(input logic [7:0] b, input logic [4:0] key,
                                        input logic dir);
        entry_t e;
        e.raw    = b;
        e.key    = key;
        e.dir    = dir;
        e.index  = '0;
        e.cap    = 1'b0;
        e.bypass = 1'b0;
        if (b >= ASCII_UPPER_LO && b <= ASCII_UPPER_HI) begin
            e.cap   = 1'b1;
            e.index = 5'(b - ASCII_UPPER_LO);
        end else if (b >= ASCII_LOWER_LO && b <= ASCII_LOWER_HI) begin
            e.index = 5'(b - ASCII_LOWER_LO);
        end else begin
            e.bypass = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [LETTERS-1:0] onehot(input logic [4:0] pos);
        return LETTERS'(1) << pos;
    endfunction

endpackage

// File: rtl/caesar_fifo2.sv
// Two-entry FIFO of classified bytes; expands letter index and key to one-hot
// at the read side so the buffer stores only compact fields.
module caesar_fifo2
    import caesar_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  entry_t             din,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [LETTERS-1:0] letter_oh,
    output logic [LETTERS-1:0] key_oh,
    output logic               en,
    output logic               cap,
    output logic               bypass,
    output logic [7:0]         raw
);

    entry_t     mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;
    entry_t     head;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 2'd1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    // Fields read as zero while empty so stale storage never leaks out.
    always_comb begin
        letter_oh = '0;
        key_oh    = '0;
        en        = 1'b0;
        cap       = 1'b0;
        bypass    = 1'b0;
        raw       = '0;
        if (!empty) begin
            if (!head.bypass) begin
                letter_oh = onehot(head.index);
            end
            key_oh = onehot(head.key - 5'd1);
            en     = head.dir;
            cap    = head.cap;
            bypass = head.bypass;
            raw    = head.raw;
        end
    end

endmodule

// File: rtl/caesar_char_frontend.sv
// Stream front-end for the Caesar datapath: key holding, byte classification and
// a 2-entry output buffer. Define CAESAR_KEY_ROLL_EN to advance the key per letter.
module caesar_char_frontend
    import caesar_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_load,
    input  logic [4:0]         key_val,
    input  logic               key_dir,
    output logic               key_err,
    output logic               key_ok,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LETTERS-1:0] letter_oh,
    output logic [LETTERS-1:0] key_oh,
    output logic               en,
    output logic               cap,
    output logic               bypass,
    output logic [7:0]         raw,
    output logic [CNT_W-1:0]   char_count
);

    state_e           state_q;
    logic [4:0]       key_q;
    logic             dir_q;
    logic             key_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic   full;
    logic   empty;
    logic   key_legal;
    logic   accept;
    logic   pop;
    entry_t entry;

    assign key_legal  = (key_val >= 5'd1) && (key_val <= 5'(LETTERS));
    assign in_ready   = (state_q == StRun) && !full;
    assign accept     = in_valid && in_ready;
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign entry      = classify(in_data, key_q, dir_q);
    assign key_ok     = (state_q == StRun);
    assign key_err    = key_err_q;
    assign char_count = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StNoKey;
            key_q     <= 5'd0;
            dir_q     <= 1'b0;
            key_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            key_err_q <= key_load && !key_legal;
            // A legal load wins over the per-letter advance in the same cycle.
            if (key_load && key_legal) begin
                key_q   <= key_val;
                dir_q   <= key_dir;
                state_q <= StRun;
            end
`ifdef CAESAR_KEY_ROLL_EN
            else if (accept && !entry.bypass) begin
                key_q <= (key_q == 5'(LETTERS)) ? 5'd1 : key_q + 5'd1;
            end
`endif
            if (accept && !entry.bypass && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    caesar_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .din       (entry),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .letter_oh (letter_oh),
        .key_oh    (key_oh),
        .en        (en),
        .cap       (cap),
        .bypass    (bypass),
        .raw       (raw)
    );

endmodule

// File: tb/tb_caesar_char_frontend.sv
// Self-checking bench for caesar_char_frontend: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_caesar_char_frontend;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_load;
    logic [4:0]       key_val;
    logic             key_dir;
    logic             key_err;
    logic             key_ok;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [25:0]      letter_oh;
    logic [25:0]      key_oh;
    logic             en;
    logic             cap;
    logic             bypass;
    logic [7:0]       raw;
    logic [CNT_W-1:0] char_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    caesar_char_frontend #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .key_val    (key_val),
        .key_dir    (key_dir),
        .key_err    (key_err),
        .key_ok     (key_ok),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .letter_oh  (letter_oh),
        .key_oh     (key_oh),
        .en         (en),
        .cap        (cap),
        .bypass     (bypass),
        .raw        (raw),
        .char_count (char_count)
    );

    // Reference model: expected output entries in arrival order plus held key state.
    typedef struct {
        logic [25:0] l;
        logic [25:0] k;
        logic        en;
        logic        cap;
        logic        byp;
        logic [7:0]  raw;
    } exp_t;

    exp_t mq[$];
    logic m_run;
    int   m_key;
    logic m_dir;
    int   m_cnt;
    logic m_err;
    logic exp_ready;
    logic obs_ready;

    function automatic exp_t make_entry(input logic [7:0] c, input int key, input logic dir);
        exp_t e;
        e.k   = 26'b1 << (key - 1);
        e.en  = dir;
        e.raw = c;
        e.cap = 1'b0;
        e.byp = 1'b0;
        e.l   = '0;
        if (c >= "A" && c <= "Z") begin
            e.cap = 1'b1;
            e.l   = 26'b1 << (c - "A");
        end else if (c >= "a" && c <= "z") begin
            e.l = 26'b1 << (c - "a");
        end else begin
            e.byp = 1'b1;
        end
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_run = 1'b0;
        m_key = 0;
        m_dir = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // One clock: drive at negedge, capture in_ready, advance model, settle after posedge.
    task automatic step(input logic kl, input logic [4:0] kv, input logic kd,
                        input logic iv, input logic [7:0] id, input logic orr);
        exp_t e;
        logic acc;
        logic pp;
        logic legal;
        @(negedge clk);
        rst_n     = 1'b1;
        key_load  = kl;
        key_val   = kv;
        key_dir   = kd;
        in_valid  = iv;
        in_data   = id;
        out_ready = orr;
        #1;
        obs_ready = in_ready;
        exp_ready = m_run && (mq.size() < 2);
        acc   = iv && exp_ready;
        pp    = (mq.size() > 0) && orr;
        legal = kl && (kv >= 1) && (kv <= 26);
        if (pp) mq.delete(0);
        e = make_entry(id, m_key, m_dir);
        if (acc) begin
            mq.push_back(e);
            if (!e.byp && m_cnt < CNT_MAX) m_cnt++;
        end
        m_err = kl && !legal;
        if (legal) begin
            m_key = int'(kv);
            m_dir = kd;
            m_run = 1'b1;
        end
`ifdef CAESAR_KEY_ROLL_EN
        else if (acc && !e.byp) begin
            m_key = (m_key == 26) ? 1 : m_key + 1;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic iv, input logic [7:0] id);
        @(negedge clk);
        rst_n     = 1'b0;
        key_load  = 1'b0;
        key_val   = 5'd0;
        key_dir   = 1'b0;
        in_valid  = iv;
        in_data   = id;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 8'h00);
        checks++;
        if ({in_ready, out_valid, key_ok, key_err, en, cap, bypass} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {in_ready, out_valid, key_ok, key_err, en, cap, bypass});
        end
        checks++;
        if ({letter_oh, key_oh, raw} !== 60'b0) begin
            errors++;
            $display("FAIL reset_data: got letter=%h key=%h raw=%h expected 0",
                     letter_oh, key_oh, raw);
        end
        checks++;
        if (char_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", char_count);
        end
    endtask

    task automatic test_no_key();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 5'd0, 1'b0, 1'b1, 8'h61, 1'b1);
            checks++;
            if (obs_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL no_key_block: got ready=%b valid=%b expected 0 0",
                         obs_ready, out_valid);
            end
        end
    endtask

    task automatic test_first_letter();
        step(1'b1, 5'd3, 1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (key_ok !== 1'b1) begin
            errors++;
            $display("FAIL key_ok_rise: got %b expected 1", key_ok);
        end
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h61, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || letter_oh !== 26'h1 || key_oh !== 26'h4) begin
            errors++;
            $display("FAIL first_letter: got valid=%b letter=%h key=%h expected 1 0000001 0000004",
                     out_valid, letter_oh, key_oh);
        end
        checks++;
        if ({en, cap, bypass} !== 3'b100 || char_count !== 16'd1) begin
            errors++;
            $display("FAIL first_flags: got en/cap/byp=%b count=%0d expected 100 1",
                     {en, cap, bypass}, char_count);
        end
    endtask

    task automatic test_mixed();
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h5A, 1'b1);
        checks++;
        if (letter_oh !== 26'h2000000 || cap !== 1'b1 || bypass !== 1'b0) begin
            errors++;
            $display("FAIL upper_z: got letter=%h cap=%b byp=%b expected 2000000 1 0",
                     letter_oh, cap, bypass);
        end
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h20, 1'b1);
        checks++;
        if (bypass !== 1'b1 || letter_oh !== 26'h0 || raw !== 8'h20 || cap !== 1'b0) begin
            errors++;
            $display("FAIL bypass_space: got byp=%b letter=%h raw=%h cap=%b expected 1 0 20 0",
                     bypass, letter_oh, raw, cap);
        end
        checks++;
        if (char_count !== 16'd2) begin
            errors++;
            $display("FAIL bypass_count: got %0d expected 2", char_count);
        end
        step(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_backpressure();
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h62, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h63, 1'b0);
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_accept: got ready=%b expected 1", obs_ready);
        end
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h64, 1'b0);
        checks++;
        if (obs_ready !== 1'b0 || raw !== 8'h62) begin
            errors++;
            $display("FAIL bp_full: got ready=%b raw=%h expected 0 62", obs_ready, raw);
        end
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h64, 1'b1);
        checks++;
        if (obs_ready !== 1'b0 || raw !== 8'h63) begin
            errors++;
            $display("FAIL bp_full_pop: got ready=%b raw=%h expected 0 63", obs_ready, raw);
        end
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h64, 1'b1);
        checks++;
        if (obs_ready !== 1'b1 || raw !== 8'h64 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_order_d: got ready=%b raw=%h valid=%b expected 1 64 1",
                     obs_ready, raw, out_valid);
        end
        step(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_key_err();
        exp_t e;
        step(1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (key_err !== 1'b1) begin
            errors++;
            $display("FAIL key_err_zero: got %b expected 1", key_err);
        end
        step(1'b1, 5'd27, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (key_err !== 1'b1) begin
            errors++;
            $display("FAIL key_err_27: got %b expected 1", key_err);
        end
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h6B, 1'b1);
        e = mq[0];
        checks++;
        if (key_err !== 1'b0 || key_oh !== e.k || en !== e.en) begin
            errors++;
            $display("FAIL key_kept: got err=%b key=%h en=%b expected 0 %h %b",
                     key_err, key_oh, en, e.k, e.en);
        end
        do_reset(1'b0, 8'h00);
        step(1'b1, 5'd0, 1'b1, 1'b1, 8'h61, 1'b1);
        checks++;
        if (key_err !== 1'b1 || key_ok !== 1'b0) begin
            errors++;
            $display("FAIL nokey_err0: got err=%b ok=%b expected 1 0", key_err, key_ok);
        end
        step(1'b1, 5'd31, 1'b1, 1'b1, 8'h61, 1'b1);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h61, 1'b1);
        checks++;
        if (key_err !== 1'b0 || key_ok !== 1'b0 || obs_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nokey_stay: got err=%b ok=%b ready=%b valid=%b expected 0 0 0 0",
                     key_err, key_ok, obs_ready, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 5'd7, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h41, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h42, 1'b0);
        do_reset(1'b1, 8'h43);
        checks++;
        if ({in_ready, out_valid, key_ok, key_err} !== 4'b0 || char_count !== '0) begin
            errors++;
            $display("FAIL mid_reset: got rdy/val/ok/err=%b count=%0d expected 0000 0",
                     {in_ready, out_valid, key_ok, key_err}, char_count);
        end
    endtask

`ifdef CAESAR_KEY_ROLL_EN
    task automatic test_roll();
        do_reset(1'b0, 8'h00);
        step(1'b1, 5'd26, 1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h61, 1'b1);
        checks++;
        if (key_oh !== 26'h2000000) begin
            errors++;
            $display("FAIL roll_first: got %h expected 2000000", key_oh);
        end
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h2E, 1'b1);
        checks++;
        if (key_oh !== 26'h1 || bypass !== 1'b1) begin
            errors++;
            $display("FAIL roll_bypass: got key=%h byp=%b expected 0000001 1", key_oh, bypass);
        end
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h62, 1'b1);
        checks++;
        if (key_oh !== 26'h1) begin
            errors++;
            $display("FAIL roll_hold: got %h expected 0000001", key_oh);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] bounds [8];
        logic [7:0] d;
        logic       kl;
        logic [4:0] kv;
        exp_t       e;
        bounds = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};
        do_reset(1'b0, 8'h00);
        step(1'b1, 5'($urandom_range(1, 26)), 1'($urandom), 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 8'h41 + 8'($urandom_range(0, 25));
                1:       d = 8'h61 + 8'($urandom_range(0, 25));
                2:       d = 8'($urandom);
                default: d = bounds[$urandom_range(0, 7)];
            endcase
            kl = ($urandom_range(0, 15) == 0);
            kv = 5'($urandom_range(0, 31));
            step(kl, kv, 1'($urandom), 1'($urandom_range(0, 3) != 0), d,
                 1'($urandom_range(0, 2) != 0));
            checks++;
            if (obs_ready !== exp_ready || out_valid !== (mq.size() > 0)) begin
                errors++;
                $display("FAIL rand_hs[%0d]: got ready=%b valid=%b expected %b %b",
                         i, obs_ready, out_valid, exp_ready, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                e = mq[0];
                checks++;
                if ({letter_oh, key_oh, en, cap, bypass, raw} !==
                    {e.l, e.k, e.en, e.cap, e.byp, e.raw}) begin
                    errors++;
                    $display("FAIL rand_entry[%0d]: got l=%h k=%h e/c/b=%b raw=%h expected l=%h k=%h e/c/b=%b raw=%h",
                             i, letter_oh, key_oh, {en, cap, bypass}, raw,
                             e.l, e.k, {e.en, e.cap, e.byp}, e.raw);
                end
            end
            checks++;
            if (key_err !== m_err || key_ok !== m_run || char_count !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL rand_status[%0d]: got err=%b ok=%b count=%0d expected %b %b %0d",
                         i, key_err, key_ok, char_count, m_err, m_run, m_cnt);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        key_load  = 1'b0;
        key_val   = 5'd0;
        key_dir   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        model_reset();
        test_reset();
        test_no_key();
        test_first_letter();
        test_mixed();
        test_backpressure();
        test_key_err();
        test_reset_midstream();
`ifdef CAESAR_KEY_ROLL_EN
        test_roll();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
